// File: rtl/bch63_pkg.sv
// bch63_pkg: shared constants, GF(64) element type, FSM states and constant
// multipliers for the BCH(63,51) t=2 serial decoder.
package bch63_pkg;
  localparam int N = 63;
  localparam int K = 51;
  localparam int M = 6;
  localparam logic [M:0] PRIM = 7'b1000011;
  typedef logic [M-1:0] gf64_t;
  typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_CHIEN} state_t;
  // alpha^6 = alpha + 1, so the overflow bit folds back into the low bits
  function automatic gf64_t gf_mul_a(gf64_t x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM[M-1:0] : gf64_t'(0));
  endfunction
  function automatic gf64_t gf_mul_a2(gf64_t x);
    return gf_mul_a(gf_mul_a(x));
  endfunction
  function automatic gf64_t gf_mul_a3(gf64_t x);
    return gf_mul_a(gf_mul_a2(x));
  endfunction
  function automatic gf64_t gf_sq(gf64_t x);
    gf64_t r;
    gf64_t p;
    r = '0;
    p = gf64_t'(1);
    for (int i = 0; i < M; i++) begin
      if (x[i]) r = r ^ p;
      p = gf_mul_a2(p);
    end
    return r;
  endfunction
endpackage

// File: rtl/bch63_decoder_gf64_mul.sv
// gf64_mul: combinational 6x6 multiplier over GF(64) modulo x^6+x+1.
module gf64_mul
  import bch63_pkg::*;
(
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] p
);
  gf64_t acc;
  gf64_t sh;
  always_comb begin
    acc = '0;
    sh = a;
    for (int i = 0; i < M; i++) begin
      acc = acc ^ (b[i] ? sh : gf64_t'(0));
      sh = gf_mul_a(sh);
    end
    p = acc;
  end
endmodule

// File: rtl/bch63_decoder.sv
// bch63_decoder: serial BCH(63,51) t=2 decoder; Horner syndromes on input,
// one key-equation cycle, then a 63-cycle inversion-free Chien search on output.
module bch63_decoder
  import bch63_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dout,
  output logic       dout_valid,
  output logic       dout_last,
  output logic [1:0] err_cnt,
  output logic       uncorr
);
  state_t state_q, state_d;
  logic [5:0] in_cnt_q, in_cnt_d, ch_cnt_q, ch_cnt_d;
  logic [N-1:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d;
  gf64_t s1_q, s1_d, s3_q, s3_d, s1o_q, s1o_d, s3o_q, s3o_d;
  gf64_t t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
  logic full_q, full_d, en_q, en_d;
  logic [1:0] deg_q, deg_d, roots_q, roots_d, roots_fin;
  logic accept, xfer, hit, chien_end;
  gf64_t s1_sq, s1_cube_a, s1_cube_b;

  gf64_mul u_cube (.a(s1_sq), .b(s1o_q), .p(s1_cube_a));
  gf64_mul u_cmp  (.a(s1o_q), .b(s1_sq), .p(s1_cube_b));

  assign s1_sq = gf_sq(s1o_q);
  assign accept = din_valid && !full_q;
  assign chien_end = (state_q == ST_CHIEN) && (ch_cnt_q == 6'd62);
  assign xfer = full_q && ((state_q == ST_IDLE) || chien_end);
  // locator scaled by S1: S1 + S1^2 x + (S1^3+S3) x^2, evaluated at x = alpha^(1+ch_cnt)
  assign hit = en_q && ((t0_q ^ t1_q ^ t2_q) == '0);
  assign roots_fin = roots_q + {1'b0, hit};

  assign din_ready = !full_q;
  assign dout_valid = state_q == ST_CHIEN;
  assign dout = dout_valid && (out_buf_q[N-1] ^ hit);
  assign dout_last = chien_end;
  assign err_cnt = chien_end ? roots_fin : 2'd0;
  assign uncorr = chien_end && (((s1o_q == '0) && (s3o_q != '0)) || (roots_fin != deg_q));

  always_comb begin
    in_cnt_d = in_cnt_q;
    in_buf_d = in_buf_q;
    s1_d = s1_q;
    s3_d = s3_q;
    full_d = full_q;
    if (xfer) begin
      full_d = 1'b0;
      in_cnt_d = '0;
      s1_d = '0;
      s3_d = '0;
    end else if (accept) begin
      in_buf_d = {in_buf_q[N-2:0], din};
      s1_d = gf_mul_a(s1_q) ^ {5'd0, din};
      s3_d = gf_mul_a3(s3_q) ^ {5'd0, din};
      in_cnt_d = (in_cnt_q == 6'd62) ? in_cnt_q : in_cnt_q + 6'd1;
      full_d = in_cnt_q == 6'd62;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_cnt_d = ch_cnt_q;
    out_buf_d = out_buf_q;
    s1o_d = s1o_q;
    s3o_d = s3o_q;
    t0_d = t0_q;
    t1_d = t1_q;
    t2_d = t2_q;
    en_d = en_q;
    deg_d = deg_q;
    roots_d = roots_q;
    case (state_q)
      ST_IDLE: state_d = xfer ? ST_KEY : ST_IDLE;
      ST_KEY: begin
        t0_d = s1o_q;
        t1_d = gf_mul_a(s1_sq);
        t2_d = gf_mul_a2(s1_cube_a ^ s3o_q);
        en_d = s1o_q != '0;
        deg_d = (s1o_q == '0) ? 2'd0 : (s3o_q == s1_cube_b) ? 2'd1 : 2'd2;
        roots_d = '0;
        ch_cnt_d = '0;
        state_d = ST_CHIEN;
      end
      ST_CHIEN: begin
        out_buf_d = {out_buf_q[N-2:0], 1'b0};
        t1_d = gf_mul_a(t1_q);
        t2_d = gf_mul_a2(t2_q);
        roots_d = roots_fin;
        ch_cnt_d = ch_cnt_q + 6'd1;
        state_d = chien_end ? (xfer ? ST_KEY : ST_IDLE) : ST_CHIEN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (xfer) begin
      out_buf_d = in_buf_q;
      s1o_d = s1_q;
      s3o_d = s3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      in_cnt_q <= '0;
      ch_cnt_q <= '0;
      in_buf_q <= '0;
      out_buf_q <= '0;
      s1_q <= '0;
      s3_q <= '0;
      s1o_q <= '0;
      s3o_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      full_q <= 1'b0;
      en_q <= 1'b0;
      deg_q <= '0;
      roots_q <= '0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      ch_cnt_q <= ch_cnt_d;
      in_buf_q <= in_buf_d;
      out_buf_q <= out_buf_d;
      s1_q <= s1_d;
      s3_q <= s3_d;
      s1o_q <= s1o_d;
      s3o_q <= s3o_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      full_q <= full_d;
      en_q <= en_d;
      deg_q <= deg_d;
      roots_q <= roots_d;
    end
  end
endmodule

// File: doc/bch63_decoder.md
# bch63_decoder

Serial hard-decision decoder for the BCH(63,51) t=2 code produced by the block's serial LFSR encoder. The code uses generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1 = m1(x)·m3(x) over GF(2^6), with primitive polynomial p(x)=x^6+x+1. The decoder takes received bits highest-degree first (coefficient x^62 first: 51 message bits, then 12 parity bits) and computes syndromes S1 and S3. It then runs an inversion-free Chien search and emits the 63 corrected bits serially in the same order, together with per-word error status.

## Interface
- No parameters. The code is fixed; all constants live in the package.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- din  in  1  received bit.
- din_valid  in  1  din qualifier; a bit is accepted when din_valid && din_ready.
- din_ready  out  1  input buffer can accept a bit.
- dout  out  1  corrected bit, valid when dout_valid.
- dout_valid  out  1  high for the 63 Chien cycles of a word.
- dout_last  out  1  high with output bit 62 (coefficient x^0).
- err_cnt  out  2  errors corrected in the word (0/1/2); valid when dout_last.
- uncorr  out  1  decoder failure for the word; valid when dout_last.

## Operation
**Input stage**
- Bit counter in_cnt runs 0..62.
- Each accepted bit shifts into in_buf[62:0] and updates the syndromes by Horner's rule: S1 ← S1·α ⊕ din, S3 ← S3·α^3 ⊕ din.
- On acceptance of bit 62: set full. din_ready = !full.

**Transfer**
- Condition: full && (state==IDLE || (state==CHIEN && ch_cnt==62)).
- Action on that edge: copy in_buf, S1, S3 to the output stage; clear full, in_cnt, S1, S3; state←KEY.

**Output FSM**
- IDLE: dout_valid=0. Go to KEY on transfer.
- KEY (1 cycle), loading:
  - T0←S1
  - T1←S1²·α
  - T2←(S1³⊕S3)·α²
  - en←(S1≠0)
  - deg←(S1≠0) ? ((S3==S1³) ? 1 : 2) : 0
  - roots←0
  - then ch_cnt←0, state←CHIEN.
- CHIEN (63 cycles, ch_cnt 0..62; position j=62−ch_cnt):
  - hit = en && (T0⊕T1⊕T2 == 0).
  - dout = out_buf[62] ⊕ hit. Then out_buf shifts left, T1←T1·α, T2←T2·α², roots+=hit.
  - At ch_cnt==62: go to KEY if transfer, else IDLE.
- Status outputs with dout_last:
  - err_cnt = roots including the current cycle's hit.
  - uncorr = (S1==0 && S3≠0) || (roots_final ≠ deg).
  - If S1==0 && S3≠0: en=0, so no bits are flipped and the word passes through uncorrected.
  - If deg==2 and no root is found: uncorr=1 and err_cnt=0.
  - Flips are never withdrawn.
- Arithmetic: all syndrome and locator values are 6-bit GF(64) elements; addition is XOR, multiplication is modulo p(x); squaring and constant multiplies are linear XOR networks.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, err_cnt=0, uncorr=0, din_ready=1, state=IDLE, full=0, all counters and syndromes 0.
- Latency: bit 62 accepted on edge k → transfer on edge k+1 → KEY → first dout_valid cycle begins after edge k+2.
- Throughput: 64 cycles per word when output-bound (one idle dout_valid cycle, KEY, between back-to-back words); the input rate is ≥63 cycles per word.
- din_ready drops the cycle after bit 62 is accepted. It rises the cycle after transfer.
- Reset asserted at any point, including mid-CHIEN, returns every register to its reset value on that edge; any partial word is discarded.
- din_valid gaps only pause the input stage; they never stall an output word in progress.

## Structure
- Package bch63_pkg holds:
  - constants N=63, K=51, M=6, PRIM=7'b1000011;
  - typedef gf64_t (6-bit);
  - constant-multiply functions ×α, ×α², ×α³ and square.
- One sub-module, gf64_mul: combinational 6×6 GF(64) multiplier.
  - Instance 1 computes S1²·S1.
  - Instance 2 computes the S1³ comparison.
  - The remaining KEY products use the constant functions.

## Test plan
- All-zero word, din_valid continuous → 63 zeros out, dout_valid rises 2 edges after bit 62; err_cnt=0, uncorr=0.
- Codeword g(x): bits x^62..x^13 = 0, x^12..x^0 = 13'h1539 → identical output; err_cnt=0.
- g(x) with bit x^62 (first bit) flipped → output equals g(x), err_cnt=1, uncorr=0.
- g(x) with x^40 and x^0 flipped → output equals g(x), err_cnt=2, uncorr=0.
- All-zero word with x^0, x^1, x^6 flipped (S1=0, S3≠0) → output equals the received word unchanged, uncorr=1.
- Three back-to-back words with din_valid held high → din_ready low during each wait and outputs in order with one idle cycle between words; reset on ch_cnt=30 of word 2 → dout_valid=0 next cycle and the following fresh word decodes correctly.
